// File: rtl/mult_pkg.sv
// mult_pkg: shared state encodings and sizing helpers for the sequential multiplier.
package mult_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int DEF_N = 5;
  function automatic int step_w(input int n);
    return $clog2(n) + 1;
  endfunction
  localparam int DEF_STEP_W = step_w(DEF_N);
endpackage

// File: rtl/mult_sched_adder.sv
// mult_sched_adder: n-bit unsigned adder with carry out.
module mult_sched_adder #(
  parameter int n = 5
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  output logic [n-1:0] o_sum,
  output logic         o_carry
);
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/mult_sched.sv
// mult_sched: two-requester round-robin scheduler around one shift-add multiplier.
module mult_sched
  import mult_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_req0,
  input  logic [N-1:0]   i_a0,
  input  logic [N-1:0]   i_b0,
  input  logic           i_req1,
  input  logic [N-1:0]   i_a1,
  input  logic [N-1:0]   i_b1,
  output logic           o_gnt0,
  output logic           o_gnt1,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_done_id,
  output logic [2*N-1:0] o_product
);
  localparam int SW = step_w(N);
  state_t         r_state, w_next;
  logic [N-1:0]   r_a;
  logic [2*N-1:0] r_p, w_p_next, r_product;
  logic [SW-1:0]  r_step;
  logic           r_id, r_last, r_gnt0, r_gnt1, r_done, r_done_id;
  logic           w_any, w_sel, w_last_step, w_take, w_gnt0_d, w_gnt1_d, w_done_d;
  logic [N-1:0]   w_s;
  logic           w_c;
  assign w_any       = i_req0 | i_req1;
  // Contention goes to whoever was not served last; a lone request always wins.
  assign w_sel       = (i_req0 & i_req1) ? ~r_last : i_req1;
  assign w_last_step = r_step == SW'(N - 1);
  mult_sched_adder #(.n(N)) u_add (
    .i_a    (r_p[2*N-1:N]),
    .i_b    (r_p[0] ? r_a : '0),
    .o_sum  (w_s),
    .o_carry(w_c)
  );
  assign w_p_next = {w_c, w_s, r_p[N-1:1]};
  always_ff @(posedge clk)
    r_state <= rst ? ST_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == ST_IDLE) w_next = w_any ? ST_RUN : ST_IDLE;
    else                    w_next = w_last_step ? ST_IDLE : ST_RUN;
  end
  always_comb begin
    w_take   = (r_state == ST_IDLE) & w_any;
    w_gnt0_d = w_take & ~w_sel;
    w_gnt1_d = w_take & w_sel;
    w_done_d = (r_state == ST_RUN) & w_last_step;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_p       <= '0;
      r_step    <= '0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_product <= '0;
    end else begin
      r_gnt0 <= w_gnt0_d;
      r_gnt1 <= w_gnt1_d;
      r_done <= w_done_d;
      if (w_take) begin
        r_a    <= w_sel ? i_a1 : i_a0;
        r_p    <= {{N{1'b0}}, (w_sel ? i_b1 : i_b0)};
        r_step <= '0;
        r_id   <= w_sel;
        r_last <= w_sel;
      end
      if (r_state == ST_RUN) begin
        r_p    <= w_p_next;
        r_step <= r_step + SW'(1);
      end
      if (w_done_d) begin
        r_product <= w_p_next;
        r_done_id <= r_id;
      end
    end
  end
  assign o_gnt0    = r_gnt0;
  assign o_gnt1    = r_gnt1;
  assign o_busy    = r_state == ST_RUN;
  assign o_done    = r_done;
  assign o_done_id = r_done_id;
  assign o_product = r_product;
endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed scenarios plus a randomized run against a cycle-count reference model.
module tb_mult_sched;
  localparam int N = 5;
  logic clk, rst;
  logic req0, req1;
  logic [N-1:0] a0, b0, a1, b1;
  logic o_gnt0, o_gnt1, o_busy, o_done, o_done_id;
  logic [2*N-1:0] o_product;
  int passed = 0;
  int total = 0;

  mult_sched #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .i_req0(req0), .i_a0(a0), .i_b0(b0),
    .i_req1(req1), .i_a1(a1), .i_b1(b1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_busy(o_busy), .o_done(o_done),
    .o_done_id(o_done_id), .o_product(o_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req0 = 1; req1 = 1; a0 = 3; b0 = 4; a1 = 7; b1 = 9;
    tick(); tick();
    total++;
    if ({o_gnt0, o_gnt1, o_busy, o_done, o_done_id, o_product} !== '0)
      $display("FAIL reset_outputs got %b %b %b %b %b %0d exp all 0", o_gnt0, o_gnt1, o_busy, o_done, o_done_id, o_product);
    else passed++;
    rst = 0;
    tick();
    total++;
    if ({o_gnt0, o_gnt1, o_busy, o_done} !== 4'b1010)
      $display("FAIL reset_first_grant got %b exp 1010", {o_gnt0, o_gnt1, o_busy, o_done});
    else passed++;
    req0 = 0; req1 = 0;
    repeat (N) tick();
    total++;
    if ({o_done, o_done_id, o_product} !== {1'b1, 1'b0, 10'd12})
      $display("FAIL reset_first_product got done=%b id=%b p=%0d exp 1 0 12", o_done, o_done_id, o_product);
    else passed++;
    tick();
  endtask

  task automatic test_single();
    req0 = 1; a0 = 31; b0 = 31;
    tick();
    total++;
    if ({o_gnt0, o_gnt1, o_busy, o_done} !== 4'b1010)
      $display("FAIL single_grant got %b exp 1010", {o_gnt0, o_gnt1, o_busy, o_done});
    else passed++;
    req0 = 0;
    for (int i = 1; i < N; i++) begin
      tick();
      total++;
      if ({o_gnt0, o_gnt1, o_busy, o_done} !== 4'b0010)
        $display("FAIL single_run%0d got %b exp 0010", i, {o_gnt0, o_gnt1, o_busy, o_done});
      else passed++;
    end
    tick();
    total++;
    if ({o_gnt0, o_gnt1, o_busy, o_done, o_done_id, o_product} !== {4'b0001, 1'b0, 10'd961})
      $display("FAIL single_done got %b id=%b p=%0d exp 0001 0 961", {o_gnt0, o_gnt1, o_busy, o_done}, o_done_id, o_product);
    else passed++;
    tick();
    total++;
    if ({o_busy, o_done, o_product} !== {2'b00, 10'd961})
      $display("FAIL single_after got busy=%b done=%b p=%0d exp 0 0 961", o_busy, o_done, o_product);
    else passed++;
  endtask

  task automatic test_zero();
    req1 = 1; a1 = 0; b1 = 27;
    tick();
    total++;
    if ({o_gnt0, o_gnt1, o_busy, o_done} !== 4'b0110)
      $display("FAIL zero_grant got %b exp 0110", {o_gnt0, o_gnt1, o_busy, o_done});
    else passed++;
    req1 = 0;
    for (int i = 1; i < N; i++) begin
      tick();
      total++;
      if ({o_busy, o_done, o_product} !== {2'b10, 10'd961})
        $display("FAIL zero_hold%0d got busy=%b done=%b p=%0d exp 1 0 961", i, o_busy, o_done, o_product);
      else passed++;
    end
    tick();
    total++;
    if ({o_busy, o_done, o_done_id, o_product} !== {3'b011, 10'd0})
      $display("FAIL zero_done got busy=%b done=%b id=%b p=%0d exp 0 1 1 0", o_busy, o_done, o_done_id, o_product);
    else passed++;
    tick();
  endtask

  task automatic test_contention();
    req0 = 1; a0 = 3; b0 = 4; req1 = 1; a1 = 7; b1 = 9;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if ({o_gnt0, o_gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL contention_grant%0d got %b%b exp %s", k, o_gnt0, o_gnt1, (k % 2 == 0) ? "10" : "01");
      else passed++;
      repeat (N) tick();
      total++;
      if ({o_done, o_done_id, o_product} !== ((k % 2 == 0) ? {2'b10, 10'd12} : {2'b11, 10'd63}))
        $display("FAIL contention_done%0d got done=%b id=%b p=%0d", k, o_done, o_done_id, o_product);
      else passed++;
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_abort();
    req0 = 1; a0 = 5; b0 = 6;
    tick();
    total++;
    if ({o_gnt0, o_gnt1, o_busy} !== 3'b101)
      $display("FAIL abort_grant got %b exp 101", {o_gnt0, o_gnt1, o_busy});
    else passed++;
    req0 = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    total++;
    if ({o_gnt0, o_gnt1, o_busy, o_done, o_done_id, o_product} !== '0)
      $display("FAIL abort_reset got busy=%b done=%b p=%0d exp all 0", o_busy, o_done, o_product);
    else passed++;
    for (int i = 0; i <= N; i++) begin
      tick();
      total++;
      if ({o_busy, o_done} !== 2'b00)
        $display("FAIL abort_no_done%0d got busy=%b done=%b exp 0 0", i, o_busy, o_done);
      else passed++;
    end
    req0 = 1; req1 = 1; a1 = 7; b1 = 9;
    tick();
    total++;
    if ({o_gnt0, o_gnt1} !== 2'b10)
      $display("FAIL abort_regrant got %b%b exp 10", o_gnt0, o_gnt1);
    else passed++;
    req0 = 0; req1 = 0;
    repeat (N) tick();
    total++;
    if ({o_done, o_done_id, o_product} !== {2'b10, 10'd30})
      $display("FAIL abort_product got done=%b id=%b p=%0d exp 1 0 30", o_done, o_done_id, o_product);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    req0 = 1; a0 = 10; b0 = 10;
    for (int r = 0; r < 3; r++) begin
      tick();
      total++;
      if ({o_gnt0, o_gnt1, o_busy, o_done} !== 4'b1010)
        $display("FAIL b2b_grant%0d got %b exp 1010", r, {o_gnt0, o_gnt1, o_busy, o_done});
      else passed++;
      for (int i = 1; i < N; i++) begin
        tick();
        total++;
        if ({o_gnt0, o_gnt1, o_busy, o_done} !== 4'b0010)
          $display("FAIL b2b_run%0d_%0d got %b exp 0010", r, i, {o_gnt0, o_gnt1, o_busy, o_done});
        else passed++;
      end
      tick();
      total++;
      if ({o_gnt0, o_gnt1, o_busy, o_done, o_done_id, o_product} !== {4'b0001, 1'b0, 10'd100})
        $display("FAIL b2b_done%0d got %b id=%b p=%0d exp 0001 0 100", r, {o_gnt0, o_gnt1, o_busy, o_done}, o_done_id, o_product);
      else passed++;
    end
    req0 = 0;
    tick();
    total++;
    if ({o_gnt0, o_gnt1, o_busy, o_done} !== 4'b0000)
      $display("FAIL b2b_idle got %b exp 0000", {o_gnt0, o_gnt1, o_busy, o_done});
    else passed++;
  endtask

  // Reference model: a granted op occupies exactly N cycles and yields a*b.
  task automatic test_random();
    bit m_run, m_last, m_id, sel, eg0, eg1, ed, do_rst;
    int m_left, m_prod;
    logic [2*N-1:0] e_prod;
    logic e_id;
    rst = 1; req0 = 0; req1 = 0;
    tick();
    rst = 0;
    m_run = 0; m_last = 1; m_id = 0; m_left = 0; m_prod = 0; e_prod = '0; e_id = 0;
    for (int c = 0; c < 400; c++) begin
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; a0 = N'($urandom); b0 = N'($urandom);
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; a1 = N'($urandom); b1 = N'($urandom);
      end
      do_rst = ($urandom_range(0, 39) == 0);
      rst = do_rst;
      tick();
      eg0 = 0; eg1 = 0; ed = 0;
      if (do_rst) begin
        m_run = 0; m_last = 1; e_prod = '0; e_id = 0;
      end else if (m_run) begin
        m_left--;
        if (m_left == 0) begin
          m_run = 0; ed = 1; e_prod = (2*N)'(m_prod); e_id = m_id;
        end
      end else if (req0 || req1) begin
        sel = (req0 && req1) ? !m_last : req1;
        eg0 = !sel; eg1 = sel;
        m_prod = sel ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
        m_id = sel; m_last = sel; m_run = 1; m_left = N;
      end
      rst = 0;
      total++;
      if ({o_gnt0, o_gnt1, o_busy, o_done} !== {eg0, eg1, m_run, ed})
        $display("FAIL rand_ctrl c=%0d got %b exp %b", c, {o_gnt0, o_gnt1, o_busy, o_done}, {eg0, eg1, m_run, ed});
      else passed++;
      total++;
      if ({o_done_id, o_product} !== {e_id, e_prod})
        $display("FAIL rand_result c=%0d got id=%b p=%0d exp id=%b p=%0d", c, o_done_id, o_product, e_id, e_prod);
      else passed++;
      if (eg0) req0 = 0;
      if (eg1) req1 = 0;
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  initial begin
    rst = 1; req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_zero();
    test_contention();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mult_sched.md
# mult_sched

Shared sequential multiplier with a round-robin scheduler between two requesters. Each granted request runs a radix-2 shift-add multiply over N clock cycles on a single N-bit adder, then returns a 2N-bit product with a one-cycle done pulse. It sits between the slide-switch/register front end and the display/LED back end, replacing a fully combinational array multiplier where area matters.

## Interface
- N, 5: operand width; legal range 2..16; product width 2N.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 wants a multiply; level, held until gnt0.
- a0, b0  in  N each  requester 0 operands; stable while req0 high.
- req1, a1, b1  in  1, N, N  requester 1, same rules.
- gnt0, gnt1  out  1 each  one-cycle grant pulse; operands were captured at the preceding edge.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse; product valid.
- done_id  out  1  requester that owns the current product (0/1).
- product  out  2N  unsigned a*b; held until the next done.

## Operation
- States: IDLE, RUN. No other states.
- IDLE: at a rising edge with any req high, select a requester, load a_r<=a_x, p_r<={N'b0, b_x}, step<=0, gnt_x<=1, id_r<=x, and go to RUN.
- Arbitration: only one req high: grant it. Both high: grant the requester that is not last_id. last_id<=x on every grant. The arbiter holds no fairness state beyond last_id.
- RUN, each edge: {c,s} = p_r[0] ? p_r[2N-1:N]+a_r : {1'b0,p_r[2N-1:N]}; p_r<={c,s,p_r[N-1:1]}; step<=step+1.
- Width rule: the N-bit add plus carry never overflows. After N steps p_r equals a*b exactly, with max (2^N-1)^2.
- On the edge completing step N-1 (the Nth step): product<=final p_r, done<=1, done_id<=id_r, state<=IDLE.
- gnt and done are registered, one-cycle pulses. They are never high in the same cycle.
- Requester contract: deassert req on the edge after it observes gnt. A req still high in IDLE is treated as a new request and granted again.
- Requests arriving during RUN wait. Inputs are not sampled in RUN.
- rst at any edge, including mid-RUN: state=IDLE. The operation is aborted with no done. gnt0=gnt1=busy=done=done_id=0, product=0, last_id=1 (requester 0 wins the first contention).

## Timing
- Request sampled at edge t: gnt_x high t..t+1, busy high t..t+N, done high t+N..t+N+1 with busy low.
- Earliest next grant is edge t+N+1. Throughput is one multiply per N+1 cycles.
- product changes only at the done edge and is stable otherwise.
- All outputs come straight from flops. No combinational input-to-output paths.

## Structure
- Shared include/package mult_pkg: state encodings (ST_IDLE, ST_RUN), default N, step-counter width localparam ($clog2(N)+1).
- One sub-module: the step add uses the team's existing parameterized adder (n=N, outputs sum and carry), instantiated once. Arbitration, FSM and shift register stay in mult_sched.

## Test plan
- Reset: hold rst 2 cycles with req0=req1=1 → all outputs 0. After release, first grant is gnt0.
- Single op, N=5: req0, a0=31, b0=31 at edge t → gnt0 at t+1, done at t+5+1 cycle window, product=961 (0x3C1), done_id=0.
- Zero operand: req1, a1=0, b1=27 → product=0, done_id=1. Previous product held until this done.
- Contention: req0 (3,4) and req1 (7,9) both held until granted → gnt0 first, product 12 id 0. Then gnt1 at edge t+6, product 63 id 1. Repeat with both high → order alternates.
- Abort: grant req0 (5,6), assert rst at step 2 → no done, product 0. Next request with req1 also pending → gnt0 (last_id reset to 1).
- Back-to-back single requester: req0 held continuously (10,10) → re-granted every 6 cycles, each done product=100. busy/done timing is exact each time.
